// File: rtl/pmp_sched_pkg.sv
// Shared types and defaults for the pattern-matching dispatch scheduler.
//   NUM_MODULES / MOD_IDX_W : number of served modules and their index width
//   FIFO_DEPTH_DEF          : default command FIFO depth
//   TIMEOUT_CYC_DEF         : default accept watchdog limit (PMP_DISP_TIMEOUT_EN only)
//   cmd_t                   : queued command {bcast, target, control, data}
package pmp_sched_pkg;

  localparam int unsigned NUM_MODULES     = 4;
  localparam int unsigned MOD_IDX_W       = 2;
  localparam int unsigned FIFO_DEPTH_DEF  = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  // control[15:14] == CTRL_NOP marks a command that only updates the slot
  localparam logic [1:0] CTRL_NOP = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE
  } state_e;

  typedef struct packed {
    logic                 bcast;
    logic [MOD_IDX_W:0]   target;
    logic [15:0]          control;
    logic [63:0]          data;
  } cmd_t;

  function automatic logic is_nop(input logic [15:0] ctrl);
    return ctrl[15:14] == CTRL_NOP;
  endfunction

endpackage

// File: rtl/pmp_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; a full FIFO refuses a push
// even when a pop happens in the same cycle.
//   clk, reset : clock, synchronous active-low reset
//   push_i     : write wdata_i when not full
//   pop_i      : drop head entry when not empty
//   rdata_o    : head entry (valid while count_o != 0)
//   count_o    : number of queued entries
module pmp_cmd_fifo #(
  parameter int unsigned WIDTH = 84,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; entries are only read when counted
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pmp_dispatch_scheduler.sv
// Command scheduler in front of the pattern-matching modules. Commands are
// queued, issued strictly in order to idle target module(s), and each
// module's data_ready is held until it reports data_accepted.
//   cmd_*          : software command input (valid/ready)
//   mod_control/mod_data/mod_ready : per-module issue slot and handshake
//   mod_accepted   : per-module data_accepted
//   mod_pattern / hit_clr / hit_status : sticky pattern hit collection
//   busy           : module has an outstanding handshake
//   fifo_count     : queued commands
//   err_badtarget  : sticky, a unicast command with invalid target was dropped
// Optional macro PMP_DISP_TIMEOUT_EN adds a per-module accept watchdog and
// the sticky err_timeout output.
module pmp_dispatch_scheduler
  import pmp_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
`ifdef PMP_DISP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_bcast,
  input  logic [MOD_IDX_W:0]          cmd_target,
  input  logic [15:0]                 cmd_control,
  input  logic [63:0]                 cmd_data,
  output logic [NUM_MODULES*16-1:0]   mod_control,
  output logic [NUM_MODULES*64-1:0]   mod_data,
  output logic [NUM_MODULES-1:0]      mod_ready,
  input  logic [NUM_MODULES-1:0]      mod_accepted,
  input  logic [NUM_MODULES-1:0]      mod_pattern,
  input  logic [NUM_MODULES-1:0]      hit_clr,
  output logic [NUM_MODULES-1:0]      hit_status,
  output logic [NUM_MODULES-1:0]      busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_badtarget
`ifdef PMP_DISP_TIMEOUT_EN
  ,
  output logic [NUM_MODULES-1:0]      err_timeout
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TGT_W = MOD_IDX_W + 1;

  cmd_t                          cmd_in, head;
  logic [CNT_W-1:0]              count;
  state_e                        state_q, state_d;
  logic                          pop_c, issue_c, err_set_c;
  logic                          head_bad, head_free;
  logic [NUM_MODULES-1:0][15:0]  ctrl_q, ctrl_d;
  logic [NUM_MODULES-1:0][63:0]  data_q, data_d;
  logic [NUM_MODULES-1:0]        ready_q, ready_d, busy_q, busy_d, hit_q, hit_d;
  logic [NUM_MODULES-1:0]        to_fire_c;
  logic                          err_bad_q, err_bad_d;

  assign cmd_in    = {cmd_bcast, cmd_target, cmd_control, cmd_data};
  assign cmd_ready = count < CNT_W'(FIFO_DEPTH);

  pmp_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (pop_c),
    .wdata_i (cmd_in),
    .rdata_o (head),
    .count_o (count)
  );

  // Head eligibility looks only at registered busy
  assign head_bad  = !head.bcast && (head.target >= TGT_W'(NUM_MODULES));
  assign head_free = head.bcast ? (busy_q == '0) : !busy_q[head.target[MOD_IDX_W-1:0]];

  // Dispatch FSM: next state and pop/issue strobes
  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    issue_c   = 1'b0;
    err_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) state_d = CHECK;
      end
      CHECK: begin
        if (count == '0) begin
          state_d = IDLE;
        end else if (head_bad) begin
          pop_c     = 1'b1;
          err_set_c = 1'b1;
          state_d   = (count > CNT_W'(1)) ? CHECK : IDLE;
        end else if (head_free) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        pop_c   = 1'b1;
        issue_c = 1'b1;
        state_d = (count > CNT_W'(1)) ? CHECK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PMP_DISP_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

  logic [NUM_MODULES-1:0][TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [NUM_MODULES-1:0]           err_to_q, err_to_d;

  // Watchdog fires on the TIMEOUT_CYC-th consecutive busy cycle
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_fire_c = '0;
    for (int unsigned i = 0; i < NUM_MODULES; i++) begin
      to_fire_c[i] = busy_q[i] && (to_cnt_q[i] == TO_W'(TIMEOUT_CYC - 1));
      to_cnt_d[i]  = busy_q[i] ? (to_cnt_q[i] + TO_W'(1)) : '0;
    end
    err_to_d = err_to_q | to_fire_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt_q <= '0;
      err_to_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout = err_to_q;
`else
  assign to_fire_c = '0;
`endif

  // Slot update, handshake release and sticky status
  always_comb begin
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    hit_d     = (hit_q & ~hit_clr) | mod_pattern;
    err_bad_d = err_bad_q | err_set_c;
    for (int unsigned i = 0; i < NUM_MODULES; i++) begin
      if ((ready_q[i] && mod_accepted[i]) || to_fire_c[i]) begin
        ready_d[i] = 1'b0;
        busy_d[i]  = 1'b0;
      end
      if (issue_c && (head.bcast || (head.target == TGT_W'(i)))) begin
        ctrl_d[i] = head.control;
        data_d[i] = head.data;
        if (!is_nop(head.control)) begin
          ready_d[i] = 1'b1;
          busy_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      data_q    <= '0;
      ready_q   <= '0;
      busy_q    <= '0;
      hit_q     <= '0;
      err_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      err_bad_q <= err_bad_d;
    end
  end

  assign mod_control   = ctrl_q;
  assign mod_data      = data_q;
  assign mod_ready     = ready_q;
  assign busy          = busy_q;
  assign hit_status    = hit_q;
  assign fifo_count    = count;
  assign err_badtarget = err_bad_q;

endmodule
